// File: rtl/fp32_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: the 24x24 significand product is
// built over four cycles from one shared 16x16 multiplier, then rounded to nearest-even.

module multiplier_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = {16'b0, a} * {16'b0, b};
endmodule

module fp32_mul_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        flag_nv_o,
  output logic        flag_of_o,
  output logic        flag_uf_o,
  output logic        flag_nx_o,
  output logic [1:0]  state_o
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // Upstream holds a_i/b_i until in_ready_o; result_o/flags hold while out_valid_o & !out_ready_i.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state;
  logic [1:0]  cnt;
  logic [47:0] acc;
  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] sig_a;
  logic [23:0] sig_b;

  assign state_o = state;

  // Operand classification; denormals count as zero.
  logic [7:0]  a_exp;
  logic [7:0]  b_exp;
  logic [22:0] a_frac;
  logic [22:0] b_frac;
  logic        a_zero;
  logic        b_zero;
  logic        a_inf;
  logic        b_inf;
  logic        a_nan;
  logic        b_nan;
  logic        a_snan;
  logic        b_snan;
  logic        in_sign;
  logic        spec_hit;
  logic [31:0] spec_result;
  logic        spec_nv;

  always_comb begin
    a_exp   = a_i[30:23];
    b_exp   = b_i[30:23];
    a_frac  = a_i[22:0];
    b_frac  = b_i[22:0];
    in_sign = a_i[31] ^ b_i[31];
    a_zero  = (a_exp == 8'h00);
    b_zero  = (b_exp == 8'h00);
    a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
    a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
    a_snan  = a_nan && !a_frac[22];
    b_snan  = b_nan && !b_frac[22];
    spec_hit = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;

    spec_result = {in_sign, 31'd0};
    spec_nv     = 1'b0;
    if (a_nan || b_nan) begin
      spec_result = QNAN;
      spec_nv     = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_result = QNAN;
      spec_nv     = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_result = {in_sign, 8'hFF, 23'd0};
    end
  end

  // Partial-product schedule: cnt picks the operand halves and the shift of the addend.
  logic [15:0] hi_a;
  logic [15:0] lo_a;
  logic [15:0] hi_b;
  logic [15:0] lo_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic [47:0] addend;

  always_comb begin
    hi_a   = {8'd0, sig_a[23:16]};
    lo_a   = sig_a[15:0];
    hi_b   = {8'd0, sig_b[23:16]};
    lo_b   = sig_b[15:0];
    mul_a  = lo_a;
    mul_b  = lo_b;
    addend = 48'd0;
    case (cnt)
      2'd0: begin
        mul_a  = lo_a;
        mul_b  = lo_b;
        addend = {16'd0, mul_p};
      end
      2'd1: begin
        mul_a  = hi_a;
        mul_b  = lo_b;
        addend = {mul_p, 16'd0};
      end
      2'd2: begin
        mul_a  = lo_a;
        mul_b  = hi_b;
        addend = {mul_p, 16'd0};
      end
      default: begin
        mul_a  = hi_a;
        mul_b  = hi_b;
        addend = {mul_p[15:0], 32'd0};
      end
    endcase
  end

  multiplier_16x16 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Normalize, round to nearest-even, then saturate to Inf or flush to zero.
  logic signed [9:0] e_pre;
  logic signed [9:0] e_fin;
  logic [22:0]       mant_sel;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [23:0]       mant_rnd;
  logic [31:0]       rnd_result;
  logic              rnd_of;
  logic              rnd_uf;
  logic              rnd_nx;

  always_comb begin
    e_pre = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127 + $signed({9'd0, acc[47]});
    if (acc[47]) begin
      mant_sel = acc[46:24];
      guard    = acc[23];
      sticky   = |acc[22:0];
    end else begin
      mant_sel = acc[45:23];
      guard    = acc[22];
      sticky   = |acc[21:0];
    end
    round_up = guard && (sticky || mant_sel[0]);
    mant_rnd = {1'b0, mant_sel} + {23'd0, round_up};
    e_fin    = mant_rnd[23] ? (e_pre + 10'sd1) : e_pre;
    rnd_nx   = guard || sticky;
    rnd_of   = 1'b0;
    rnd_uf   = 1'b0;
    rnd_result = {sign, e_fin[7:0], mant_rnd[22:0]};
    if (e_fin >= 10'sd255) begin
      rnd_result = {sign, 8'hFF, 23'd0};
      rnd_of     = 1'b1;
      rnd_nx     = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      rnd_result = {sign, 31'd0};
      rnd_uf     = 1'b1;
      rnd_nx     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      acc         <= 48'd0;
      sign        <= 1'b0;
      ea          <= 8'd0;
      eb          <= 8'd0;
      sig_a       <= 24'd0;
      sig_b       <= 24'd0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= 32'd0;
      flag_nv_o   <= 1'b0;
      flag_of_o   <= 1'b0;
      flag_uf_o   <= 1'b0;
      flag_nx_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            in_ready_o <= 1'b0;
            sign       <= in_sign;
            ea         <= a_exp;
            eb         <= b_exp;
            sig_a      <= {1'b1, a_frac};
            sig_b      <= {1'b1, b_frac};
            acc        <= 48'd0;
            cnt        <= 2'd0;
            if (spec_hit) begin
              result_o    <= spec_result;
              flag_nv_o   <= spec_nv;
              flag_of_o   <= 1'b0;
              flag_uf_o   <= 1'b0;
              flag_nx_o   <= 1'b0;
              out_valid_o <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc <= acc + addend;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_ROUND;
        end
        S_ROUND: begin
          result_o    <= rnd_result;
          flag_nv_o   <= 1'b0;
          flag_of_o   <= rnd_of;
          flag_uf_o   <= rnd_uf;
          flag_nx_o   <= rnd_nx;
          out_valid_o <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
